// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared constants and FSM encoding for the 3x3 window generator
package conv_window_gen_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 4;
    localparam int DEF_IMG_HEIGHT = 4;
    localparam int WIN_SIZE       = 3;
    localparam int WIN_ELEMS      = WIN_SIZE * WIN_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: memory read port plus window valid/ready stream of the window generator
interface conv_window_gen_if import conv_window_gen_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
);

    logic                                start;
    logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] mem_addr;
    logic signed [DATA_WIDTH-1:0]        mem_dout;
    logic                                win_valid;
    logic                                win_ready;
    logic [WIN_ELEMS*DATA_WIDTH-1:0]     win_data;
    logic [$clog2(IMG_HEIGHT)-1:0]       win_row;
    logic [$clog2(IMG_WIDTH)-1:0]        win_col;
    logic                                busy;
    logic                                done;

    modport master (
        input  start, mem_dout, win_ready,
        output mem_addr, win_valid, win_data, win_row, win_col, busy, done
    );

    modport slave (
        output start, mem_dout, win_ready,
        input  mem_addr, win_valid, win_data, win_row, win_col, busy, done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// conv_window_gen_line_buffer: one-row pixel delay that only advances when a pixel is accepted
module conv_window_gen_line_buffer import conv_window_gen_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q, sr_d;

    // shift a new pixel in at the bottom; the oldest one falls out the top
    always_comb begin
        sr_d = en ? {sr_q[DEPTH-2:0], din} : sr_q;
    end

    // contents are don't-care until a full row has passed, so no reset is needed
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-scan 3x3 valid-padding window generator fed from a combinational-read memory
module conv_window_gen import conv_window_gen_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input logic               clk,
    input logic               rst_n,
    conv_window_gen_if.master bus
);

    localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);

    state_t                               state_q, state_d;
    logic [AW-1:0]                        p_q, p_d;
    logic [RW-1:0]                        r_q, r_d, row_q, row_d;
    logic [CW-1:0]                        c_q, c_d, col_q, col_d;
    logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic                                 valid_q, valid_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 stall, accept, handshake, row_end, last_pix;
    logic [DATA_WIDTH-1:0]                above1, above2;

    assign stall     = valid_q & ~bus.win_ready;
    assign handshake = valid_q & bus.win_ready;
    assign accept    = (state_q == SCAN) & ~stall;
    assign row_end   = c_q == CW'(IMG_WIDTH - 1);
    assign last_pix  = p_q == AW'(IMG_WIDTH * IMG_HEIGHT - 1);

    conv_window_gen_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk (clk),
        .en  (accept),
        .din (bus.mem_dout),
        .dout(above1)
    );

    conv_window_gen_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk (clk),
        .en  (accept),
        .din (above1),
        .dout(above2)
    );

    // FSM, pixel counter, window shift register and output handshake next-state
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        r_d     = r_q;
        c_d     = c_q;
        win_d   = win_q;
        valid_d = valid_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SCAN;
                p_d     = '0;
                r_d     = '0;
                c_d     = '0;
            end
            SCAN: if (accept) begin
                p_d = p_q + AW'(1);
                c_d = row_end ? '0 : c_q + CW'(1);
                r_d = row_end ? r_q + RW'(1) : r_q;
                if (last_pix) state_d = DRAIN;
            end
            DRAIN: if (handshake) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                win_d[i*WIN_SIZE]     = win_q[i*WIN_SIZE+1];
                win_d[i*WIN_SIZE+1]   = win_q[i*WIN_SIZE+2];
            end
            win_d[WIN_SIZE-1]   = above2;
            win_d[2*WIN_SIZE-1] = above1;
            win_d[WIN_ELEMS-1]  = bus.mem_dout;
            valid_d = (r_q >= RW'(2)) && (c_q >= CW'(2));
            row_d   = r_q - RW'(2);
            col_d   = c_q - CW'(2);
        end else if (handshake) begin
            valid_d = 1'b0;
        end
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            r_q     <= r_d;
            c_q     <= c_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_addr  = (state_q == SCAN) ? p_q : '0;
    assign bus.win_valid = valid_q;
    assign bus.win_data  = win_q;
    assign bus.win_row   = row_q;
    assign bus.win_col   = col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
